clause_status_collector: RTL and testbench
==========================================

// Module: clause_status_collector
// PURPOSE
//   Receiving end of the per-clause terminal-cell drive lines in the clause array.
//   After each BCP round it samples every slot's csat/imp/conflict/cmax_lvl drives.
//   It reduces them to one result: lowest-index conflicting clause and its max level, all-sat, and unit-pending.
//   It hands the result to conflict analysis over a valid/ready handshake and drives apply_analyze back to the array.
// PARAMETERS
//   NUM_C        8   clause slots in the array
//   WIDTH_LVL    16  decision-level width; matches terminal-cell cmax_lvl
//   WIDTH_CID    3   clause-index width, >= clog2(NUM_C)
//   SETTLE_CYC   2   cycles waited after start_i for the combinational drive chain to settle (>=1)
// PORTS
//   clk               in   1                  clock
//   rst               in   1                  synchronous reset, active-low
//   start_i           in   1                  pulse: BCP round applied, collect status
//   c_valid_i         in   NUM_C              slot holds a clause (clause_len != 0)
//   csat_drv_i        in   NUM_C              per-slot clause-satisfied drive
//   imp_drv_i         in   NUM_C              per-slot unit/implication drive
//   conflict_c_drv_i  in   NUM_C              per-slot conflict drive
//   cmax_lvl_i        in   NUM_C*WIDTH_LVL    per-slot max level; slot k at [k*WIDTH_LVL +: WIDTH_LVL]
//   busy_o            out  1                  state != IDLE
//   result_valid_o    out  1                  result registers valid
//   result_ready_i    in   1                  analysis unit accepts result
//   conflict_o        out  1                  at least one valid slot in conflict
//   conflict_cid_o    out  WIDTH_CID          lowest conflicting slot index
//   conflict_lvl_o    out  WIDTH_LVL          cmax_lvl of that slot
//   all_sat_o         out  1                  every valid slot satisfied
//   imp_pending_o     out  1                  some valid, unsatisfied slot has imp_drv
//   apply_analyze_o   out  1                  to terminal cells: analysis in progress
//   done_o            out  1                  1-cycle pulse on result handshake
// BEHAVIOUR
//   Reset (rst==0 at posedge): state=IDLE; all outputs 0. Takes priority over every other event, including mid-SCAN/REPORT.
//   FSM: IDLE -start_i-> SETTLE -> SAMPLE -> SCAN -> REPORT -(valid&ready)-> IDLE.
//   - IDLE: start_i=1 loads settle counter with SETTLE_CYC-1 and enters SETTLE.
//     start_i outside IDLE is ignored; no queuing.
//   - SETTLE: counter decrements each cycle; exits to SAMPLE when it reads 0.
//     Exactly SETTLE_CYC cycles are spent in SETTLE.
//   - SAMPLE: one cycle. Snapshot all input vectors into registers.
//     Input changes after this cycle do not affect the result.
//     Clear accumulators: conflict=0, all_sat=1, imp_pending=0. Scan index=0.
//   - SCAN: one slot per cycle, index 0..NUM_C-1, NUM_C cycles total. Per slot k with snap c_valid[k]=1:
//     - !csat[k] -> all_sat=0.
//     - imp[k] & !csat[k] -> imp_pending=1.
//     - conflict[k] & !conflict -> conflict=1, cid=k, lvl=cmax_lvl[k]. First (lowest) conflict wins.
//     - Invalid slots contribute nothing.
//     - No valid slots at all -> all_sat=1, conflict=0.
//     - Conflict and all_sat are both reported as sampled; no masking.
//     - Index wraps to 0 after NUM_C-1 and the FSM enters REPORT.
//   - REPORT:
//     - result_valid_o=1; result outputs are stable while valid.
//     - apply_analyze_o = conflict_o.
//     - result_valid_o and result_ready_i high in the same cycle completes the handshake:
//       next cycle IDLE, result_valid_o=0, apply_analyze_o=0, done_o=1 for one cycle.
//     - result_ready_i held high before REPORT is legal; the handshake completes on the first REPORT cycle.
//     - Result data outputs (conflict_o..imp_pending_o) hold their value in IDLE until the next SAMPLE.
//   Latency:
//     - start_i sampled at edge t -> result_valid_o high from edge t+SETTLE_CYC+NUM_C+2 (12 with defaults).
//     - Minimum round trip with ready tied high: SETTLE_CYC+NUM_C+3 cycles.
// CONFIGURATION
//   CLAUSE_COLLECT_STATS_EN defined:
//     - Adds outputs round_cnt_o[31:0] and conflict_cnt_o[31:0].
//     - Both counters are reset to 0.
//     - round_cnt_o increments on each handshake; conflict_cnt_o increments on each handshake where conflict_o=1.
//     - Both wrap at 2^32.
//   CLAUSE_COLLECT_STATS_EN undefined: these ports and registers are absent; all other behaviour is identical.
// TESTING
//   1. Reset: rst=0 for 2 cycles mid-SCAN -> busy_o=0, result_valid_o=0, and all outputs 0 on the next cycle.
//   2. All 8 slots valid and csat=1, start at edge 0, ready=1 -> valid at edge 12 with all_sat=1, conflict=0; done_o at edge 13.
//   3. Conflicts in slots 5 (lvl 7) and 2 (lvl 9) -> conflict_o=1, cid=2, lvl=9, apply_analyze_o=1 until handshake.
//   4. Slot 3 imp=1 csat=0 and slot 6 imp=1 csat=1, no conflict -> imp_pending_o=1, all_sat_o=0.
//   5. ready=0 for 5 REPORT cycles; inputs and a second start_i toggled during REPORT:
//      - outputs stay stable, second start ignored;
//      - ready=1 -> exactly one done_o pulse.
//   6. c_valid_i=0 with conflict_c_drv_i=8'hFF -> conflict_o=0, all_sat_o=1.
//      With stats enabled, after scenarios 2-3: round_cnt=2, conflict_cnt=1.

Source files
------------

// File: rtl/clause_status_collector_if.sv
// Signal bundle between the clause array / analysis unit and clause_status_collector.
// The collector uses the slave modport; the array/analysis side uses master.
interface clause_status_collector_if #(
    parameter int NUM_C     = 8,
    parameter int WIDTH_LVL = 16,
    parameter int WIDTH_CID = 3
);
    logic                       start_i;
    logic [NUM_C-1:0]           c_valid_i;
    logic [NUM_C-1:0]           csat_drv_i;
    logic [NUM_C-1:0]           imp_drv_i;
    logic [NUM_C-1:0]           conflict_c_drv_i;
    logic [NUM_C*WIDTH_LVL-1:0] cmax_lvl_i;
    logic                       busy_o;
    logic                       result_valid_o;
    logic                       result_ready_i;
    logic                       conflict_o;
    logic [WIDTH_CID-1:0]       conflict_cid_o;
    logic [WIDTH_LVL-1:0]       conflict_lvl_o;
    logic                       all_sat_o;
    logic                       imp_pending_o;
    logic                       apply_analyze_o;
    logic                       done_o;

    modport slave (
        input  start_i, c_valid_i, csat_drv_i, imp_drv_i, conflict_c_drv_i, cmax_lvl_i,
        input  result_ready_i,
        output busy_o, result_valid_o, conflict_o, conflict_cid_o, conflict_lvl_o,
        output all_sat_o, imp_pending_o, apply_analyze_o, done_o
    );

    modport master (
        output start_i, c_valid_i, csat_drv_i, imp_drv_i, conflict_c_drv_i, cmax_lvl_i,
        output result_ready_i,
        input  busy_o, result_valid_o, conflict_o, conflict_cid_o, conflict_lvl_o,
        input  all_sat_o, imp_pending_o, apply_analyze_o, done_o
    );
endinterface

// File: rtl/clause_status_collector.sv
// Collects per-clause terminal-cell drives after a BCP round and reduces them to one result for conflict analysis.
// Optional CLAUSE_COLLECT_STATS_EN adds round/conflict counters (round_cnt_o, conflict_cnt_o).
module clause_status_collector #(
    parameter int NUM_C      = 8,
    parameter int WIDTH_LVL  = 16,
    parameter int WIDTH_CID  = 3,
    parameter int SETTLE_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    clause_status_collector_if.slave bus
`ifdef CLAUSE_COLLECT_STATS_EN
    ,
    output logic [31:0]              round_cnt_o,
    output logic [31:0]              conflict_cnt_o
`endif
);

    localparam int WIDTH_SET = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [WIDTH_SET-1:0] SETTLE_INIT = WIDTH_SET'(SETTLE_CYC - 1);
    localparam logic [WIDTH_CID-1:0] LAST_IDX    = WIDTH_CID'(NUM_C - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_SCAN,
        S_REPORT
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_start;
    logic [WIDTH_SET-1:0]   r_settle_cnt;
    logic [WIDTH_CID-1:0]   r_idx;

    logic [NUM_C-1:0]       r_valid_snap;
    logic [NUM_C-1:0]       r_csat_snap;
    logic [NUM_C-1:0]       r_imp_snap;
    logic [NUM_C-1:0]       r_conf_snap;
    logic [WIDTH_LVL-1:0]   r_lvl_snap [NUM_C];

    logic                   r_conflict;
    logic [WIDTH_CID-1:0]   r_cid;
    logic [WIDTH_LVL-1:0]   r_lvl;
    logic                   r_all_sat;
    logic                   r_imp_pending;
    logic                   r_done;

    logic                   w_handshake;
    logic                   w_slot_valid;
    logic                   w_slot_csat;
    logic                   w_slot_imp;
    logic                   w_slot_conf;
    logic [WIDTH_LVL-1:0]   w_slot_lvl;

    assign w_handshake  = (r_state == S_REPORT) && bus.result_ready_i;
    assign w_slot_valid = r_valid_snap[r_idx];
    assign w_slot_csat  = r_csat_snap[r_idx];
    assign w_slot_imp   = r_imp_snap[r_idx];
    assign w_slot_conf  = r_conf_snap[r_idx];
    assign w_slot_lvl   = r_lvl_snap[r_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every variable assigned in always_comb gets its default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_start) w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_settle_cnt == '0) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = S_SCAN;
            S_SCAN:   if (r_idx == LAST_IDX) w_state_nxt = S_REPORT;
            S_REPORT: if (bus.result_ready_i) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // start_i is registered; only a pulse seen while idle can launch a round.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_start       <= 1'b0;
            r_settle_cnt  <= '0;
            r_idx         <= '0;
            r_conflict    <= 1'b0;
            r_cid         <= '0;
            r_lvl         <= '0;
            r_all_sat     <= 1'b0;
            r_imp_pending <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_start <= bus.start_i && (r_state == S_IDLE);
            r_done  <= w_handshake;
            case (r_state)
                S_IDLE: begin
                    if (r_start) r_settle_cnt <= SETTLE_INIT;
                end
                S_SETTLE: begin
                    if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - 1'b1;
                end
                S_SAMPLE: begin
                    r_conflict    <= 1'b0;
                    r_cid         <= '0;
                    r_lvl         <= '0;
                    r_all_sat     <= 1'b1;
                    r_imp_pending <= 1'b0;
                    r_idx         <= '0;
                end
                S_SCAN: begin
                    if (w_slot_valid) begin
                        if (!w_slot_csat) r_all_sat <= 1'b0;
                        if (w_slot_imp && !w_slot_csat) r_imp_pending <= 1'b1;
                        if (w_slot_conf && !r_conflict) begin
                            r_conflict <= 1'b1;
                            r_cid      <= r_idx;
                            r_lvl      <= w_slot_lvl;
                        end
                    end
                    r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the snapshot is pure data, always written in SAMPLE before SCAN reads it, so it carries no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_SAMPLE) begin
            r_valid_snap <= bus.c_valid_i;
            r_csat_snap  <= bus.csat_drv_i;
            r_imp_snap   <= bus.imp_drv_i;
            r_conf_snap  <= bus.conflict_c_drv_i;
            for (int k = 0; k < NUM_C; k++) begin
                r_lvl_snap[k] <= bus.cmax_lvl_i[k*WIDTH_LVL +: WIDTH_LVL];
            end
        end
    end

    assign bus.busy_o          = (r_state != S_IDLE);
    assign bus.result_valid_o  = (r_state == S_REPORT);
    assign bus.apply_analyze_o = (r_state == S_REPORT) && r_conflict;
    assign bus.conflict_o      = r_conflict;
    assign bus.conflict_cid_o  = r_cid;
    assign bus.conflict_lvl_o  = r_lvl;
    assign bus.all_sat_o       = r_all_sat;
    assign bus.imp_pending_o   = r_imp_pending;
    assign bus.done_o          = r_done;

`ifdef CLAUSE_COLLECT_STATS_EN
    logic [31:0] r_round_cnt;
    logic [31:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_round_cnt    <= '0;
            r_conflict_cnt <= '0;
        end else if (w_handshake) begin
            r_round_cnt <= r_round_cnt + 32'd1;
            if (r_conflict) r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign round_cnt_o    = r_round_cnt;
    assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_clause_status_collector.sv
// Scoreboard bench for clause_status_collector: directed rounds push expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_clause_status_collector;

    localparam int NUM_C     = 8;
    localparam int WL        = 16;
    localparam int WC        = 3;

    typedef struct packed {
        logic          conflict;
        logic [WC-1:0] cid;
        logic [WL-1:0] lvl;
        logic          all_sat;
        logic          imp_pending;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    clause_status_collector_if #(.NUM_C(NUM_C), .WIDTH_LVL(WL), .WIDTH_CID(WC)) u_if ();

`ifdef CLAUSE_COLLECT_STATS_EN
    logic [31:0] round_cnt;
    logic [31:0] conflict_cnt;
`endif

    clause_status_collector #(
        .NUM_C(NUM_C), .WIDTH_LVL(WL), .WIDTH_CID(WC), .SETTLE_CYC(2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
`ifdef CLAUSE_COLLECT_STATS_EN
        ,
        .round_cnt_o    (round_cnt),
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst && u_if.result_valid_o && u_if.result_ready_i) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_conflict", u_if.conflict_o, e.conflict);
                check("sb_all_sat", u_if.all_sat_o, e.all_sat);
                check("sb_imp_pending", u_if.imp_pending_o, e.imp_pending);
                check("sb_apply_analyze", u_if.apply_analyze_o, e.conflict);
                if (e.conflict) begin
                    check("sb_cid", u_if.conflict_cid_o, e.cid);
                    check("sb_lvl", u_if.conflict_lvl_o, e.lvl);
                end
            end
        end
    end

    function automatic logic [NUM_C*WL-1:0] base_lvls();
        logic [NUM_C*WL-1:0] v;
        for (int k = 0; k < NUM_C; k++) v[k*WL +: WL] = WL'(100 + k);
        return v;
    endfunction

    task automatic drive(input logic [7:0] cv, input logic [7:0] cs, input logic [7:0] im,
                         input logic [7:0] cf, input logic [NUM_C*WL-1:0] lv);
        u_if.c_valid_i        = cv;
        u_if.csat_drv_i       = cs;
        u_if.imp_drv_i        = im;
        u_if.conflict_c_drv_i = cf;
        u_if.cmax_lvl_i       = lv;
    endtask

    task automatic scramble();
        drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              {$urandom, $urandom, $urandom, $urandom});
    endtask

    // Launches a round with start_i sampled at edge t; returns just after edge t.
    task automatic pulse_start();
        @(posedge clk); #1 u_if.start_i = 1'b1;
        @(posedge clk); #1 u_if.start_i = 1'b0;
    endtask

    task automatic run_round(input logic [7:0] cv, input logic [7:0] cs, input logic [7:0] im,
                             input logic [7:0] cf, input logic [NUM_C*WL-1:0] lv, input exp_t e,
                             input int hold, input bit scramble_scan, input bit disturb);
        int n;
        int dones;
        logic seen;
        drive(cv, cs, im, cf, lv);
        sb_q.push_back(e);
        u_if.result_ready_i = (hold == 0);
        pulse_start();
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            n++;
            if (scramble_scan && n == 6) begin
                #1 scramble();
            end
            @(negedge clk);
            seen = u_if.result_valid_o;
        end
        check("valid_seen", seen, 1'b1);
        check("latency", n, 12);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", u_if.result_valid_o, 1'b1);
            check("hold_apply", u_if.apply_analyze_o, e.conflict);
            check("hold_conflict", u_if.conflict_o, e.conflict);
            check("hold_all_sat", u_if.all_sat_o, e.all_sat);
            check("hold_imp", u_if.imp_pending_o, e.imp_pending);
            if (e.conflict) check("hold_cid_lvl", {u_if.conflict_cid_o, u_if.conflict_lvl_o}, {e.cid, e.lvl});
            @(posedge clk);
            #1;
            if (h == hold - 1) u_if.result_ready_i = 1'b1;
            else if (disturb && h == 1) begin scramble(); u_if.start_i = 1'b1; end
            else if (disturb && h == 2) begin u_if.start_i = 1'b0; scramble(); end
            @(negedge clk);
        end
        // Handshake negedge is now; the monitor compares it.
        @(negedge clk);
        check("post_valid", u_if.result_valid_o, 1'b0);
        check("post_apply", u_if.apply_analyze_o, 1'b0);
        dones = int'(u_if.done_o);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dones += int'(u_if.done_o);
        end
        check("done_pulses", dones, 1);
        check("idle_busy", u_if.busy_o, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, u_if.busy_o, 1'b0);
        check({tag, "_valid"}, u_if.result_valid_o, 1'b0);
        check({tag, "_data"}, {u_if.conflict_o, u_if.conflict_cid_o, u_if.conflict_lvl_o,
                               u_if.all_sat_o, u_if.imp_pending_o}, 32'd0);
        check({tag, "_apply_done"}, {u_if.apply_analyze_o, u_if.done_o}, 32'd0);
    endtask

    initial begin
        logic [NUM_C*WL-1:0] lv;
        exp_t e;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        u_if.start_i = 1'b0;
        u_if.result_ready_i = 1'b0;
        drive(8'h00, 8'h00, 8'h00, 8'h00, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #1 rst = 1'b1;

        // All valid and satisfied, ready tied high.
        e = '{conflict: 1'b0, cid: '0, lvl: '0, all_sat: 1'b1, imp_pending: 1'b0};
        run_round(8'hFF, 8'hFF, 8'h00, 8'h00, base_lvls(), e, 0, 1'b0, 1'b0);

        // Conflicts in slots 5 (lvl 7) and 2 (lvl 9): lowest index wins.
        lv = base_lvls();
        lv[5*WL +: WL] = 16'd7;
        lv[2*WL +: WL] = 16'd9;
        e = '{conflict: 1'b1, cid: 3'd2, lvl: 16'd9, all_sat: 1'b0, imp_pending: 1'b0};
        run_round(8'hFF, 8'hDB, 8'h00, 8'h24, lv, e, 2, 1'b0, 1'b0);
`ifdef CLAUSE_COLLECT_STATS_EN
        check("round_cnt", round_cnt, 32'd2);
        check("conflict_cnt", conflict_cnt, 32'd1);
`endif

        // Unit pending on slot 3; slot 6 implied but satisfied; inputs scrambled during SCAN.
        e = '{conflict: 1'b0, cid: '0, lvl: '0, all_sat: 1'b0, imp_pending: 1'b1};
        run_round(8'hFF, 8'hF7, 8'h48, 8'h00, base_lvls(), e, 0, 1'b1, 1'b0);

        // Five stalled REPORT cycles with inputs and a second start toggled.
        lv = base_lvls();
        lv[3*WL +: WL] = 16'h1234;
        e = '{conflict: 1'b1, cid: 3'd3, lvl: 16'h1234, all_sat: 1'b0, imp_pending: 1'b1};
        run_round(8'h0F, 8'h01, 8'h04, 8'h08, lv, e, 5, 1'b0, 1'b1);

        // No valid slots: conflicts ignored, vacuously all satisfied.
        e = '{conflict: 1'b0, cid: '0, lvl: '0, all_sat: 1'b1, imp_pending: 1'b0};
        run_round(8'h00, 8'h00, 8'hFF, 8'hFF, base_lvls(), e, 0, 1'b0, 1'b0);

        // Reset asserted for two cycles in the middle of SCAN.
        lv = base_lvls();
        lv[0 +: WL] = 16'd5;
        drive(8'hFF, 8'hFF, 8'h00, 8'h01, lv);
        u_if.result_ready_i = 1'b0;
        pulse_start();
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("mid_scan_busy", u_if.busy_o, 1'b1);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_scan_rst");
        @(posedge clk);
        #1 rst = 1'b1;
`ifdef CLAUSE_COLLECT_STATS_EN
        check("rst_round_cnt", round_cnt, 32'd0);
`endif

        // Recovery round after reset.
        e = '{conflict: 1'b1, cid: 3'd0, lvl: 16'd5, all_sat: 1'b1, imp_pending: 1'b0};
        run_round(8'hFF, 8'hFF, 8'h00, 8'h01, lv, e, 0, 1'b0, 1'b0);
`ifdef CLAUSE_COLLECT_STATS_EN
        check("final_round_cnt", round_cnt, 32'd1);
        check("final_conflict_cnt", conflict_cnt, 32'd1);
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
